// File: rtl/sp_mem_rr_arbiter.sv
// rtl/sp_mem_rr_arbiter.sv - round-robin arbiter sharing one single-port memory between NumReq requesters
module sp_mem_rr_arbiter #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 8,
    parameter int DataDepth = 4096,
    parameter int AddrWidth = (DataDepth <= 1) ? 1 : $clog2(DataDepth),
    parameter int CntWidth  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_valid_i,
    input  logic [NumReq-1:0]             req_we_i,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*DataWidth-1:0]   req_wr_data_i,
    output logic [NumReq-1:0]             req_ready_o,
    output logic [NumReq-1:0]             rsp_valid_o,
    output logic [DataWidth-1:0]          rsp_rd_data_o,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic                          mem_we_o,
    output logic [DataWidth-1:0]          mem_wr_data_o,
    input  logic [DataWidth-1:0]          mem_rd_data_i,
    output logic [CntWidth-1:0]           conflict_cnt_o
);

    localparam int PtrWidth = $clog2(NumReq);

    logic [PtrWidth-1:0]  ptr_q;
    logic [PtrWidth-1:0]  gnt_idx;
    logic                 found;
    logic                 gnt_any;
    logic [NumReq-1:0]    gnt_oh;
    logic [NumReq-1:0]    rd_gnt_q;
    logic [CntWidth-1:0]  conflict_cnt_q;
    logic                 conflict;

    // Two passes: indices at or above ptr first, then the wrapped-around low indices.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (!found && (k >= int'(ptr_q)) && req_valid_i[k]) begin
                found   = 1'b1;
                gnt_idx = PtrWidth'(k);
            end
        end
        for (int k = 0; k < NumReq; k++) begin
            if (!found && req_valid_i[k]) begin
                found   = 1'b1;
                gnt_idx = PtrWidth'(k);
            end
        end
    end

    // Reset suppresses the grant so every memory-side output reads zero while held.
    assign gnt_any = found & rst_ni;

    always_comb begin
        gnt_oh = '0;
        for (int k = 0; k < NumReq; k++) begin
            gnt_oh[k] = gnt_any && (gnt_idx == PtrWidth'(k));
        end
    end

    always_comb begin
        mem_addr_o    = '0;
        mem_wr_data_o = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (gnt_oh[k]) begin
                mem_addr_o    = req_addr_i[k*AddrWidth +: AddrWidth];
                mem_wr_data_o = req_wr_data_i[k*DataWidth +: DataWidth];
            end
        end
    end

    assign mem_we_o       = |(gnt_oh & req_we_i);
    assign req_ready_o    = gnt_oh;
    assign rsp_valid_o    = rd_gnt_q & {NumReq{rst_ni}};
    assign rsp_rd_data_o  = mem_rd_data_i;
    assign conflict       = ($countones(req_valid_i) >= 2);
    assign conflict_cnt_o = conflict_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q          <= '0;
            rd_gnt_q       <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (gnt_any) begin
                ptr_q <= (gnt_idx == PtrWidth'(NumReq - 1)) ? '0 : gnt_idx + PtrWidth'(1);
            end
            rd_gnt_q <= mem_we_o ? '0 : gnt_oh;
            if (conflict && (conflict_cnt_q != {CntWidth{1'b1}})) begin
                conflict_cnt_q <= conflict_cnt_q + CntWidth'(1);
            end
        end
    end

endmodule
